byte_striping_n: RTL and testbench
==================================

Name: byte_striping_n

Overview:
- Parametrised successor to the two-lane byte striper.
- Runs on a single clock. Accepts one DATA_W word per cycle through a valid/ready handshake and distributes the words round-robin over NUM_LANES lanes.
- Presents each completed lane group in parallel through a held valid/ready output stage.
- Supports partial-group flush with padding and per-lane valid flags. Sits between the PHY transmit framing logic and the per-lane encoders.

Parameters:
DATA_W, 32, width of one lane word
NUM_LANES, 4, lane count; legal range 2..16
PAD_WORD, 0, value driven on unfilled lanes of a flushed partial group
CNT_W, 16, width of the group counter

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
data_in  input  DATA_W  input word; ignored when valid_in=0
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a word this cycle
flush_in  input  1  close the current partial group (one-shot per cycle)
lanes_out  output  NUM_LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
lane_valid  output  NUM_LANES  bit k=1 if lane k carries real data
group_valid  output  1  lanes_out/lane_valid hold a group
group_ready  input  1  consumer accepts the group
lane_ptr  output  clog2(NUM_LANES)  next accumulator slot to fill
group_count  output  CNT_W  groups handed off, wraps modulo 2^CNT_W

Behaviour:
- Reset: clock and reset interface fixed as one clock `clk`; reset is synchronous and active-high.
- Reset values: lanes_out=0, lane_valid=0, group_valid=0, lane_ptr=0, group_count=0; accumulator and pending flag cleared.
- ready_out = !reset && !pending (combinational). It is 1 the first cycle after reset deasserts.
- Reset mid-operation discards any partial group and any held output group.
- Accept: a word is accepted when valid_in && ready_out. It is written to accumulator slot lane_ptr and its slot-filled bit is set.
- lane_ptr increments on each accept and wraps NUM_LANES-1 -> 0.
- Group completion event occurs in a cycle when either condition holds:
  - (a) a word is accepted into slot NUM_LANES-1;
  - (b) flush_in=1 and at least one slot is filled, counting a word accepted in the same cycle.
- (a) and (b) in the same cycle produce exactly one full group.
- flush_in with an empty accumulator is a no-op. flush_in while pending=1 is ignored.
- Transfer to output happens at the clock edge if a completion or pending group exists and the output is free. The output is free when group_valid=0, or when group_valid && group_ready in this cycle.
- On transfer:
  - lanes_out gets the slot contents, with PAD_WORD in unfilled slots;
  - lane_valid gets the filled bits;
  - group_valid=1;
  - accumulator filled bits clear and lane_ptr resets to 0;
  - group_count increments.
- If a completion occurs while the output is not free, pending is set and ready_out drops the next cycle. The accumulator holds its contents until the transfer, then pending clears.
- Latency: the word completing a group is accepted in cycle t; group_valid is high in cycle t+1 when the output is free.
- Output hold: lanes_out, lane_valid and group_valid stay stable while group_valid && !group_ready.
- The output clears (group_valid=0, lane_valid=0) on a handshake unless a new group transfers on the same edge.
- Back-to-back: with group_ready held at 1, a continuous input yields one group every NUM_LANES cycles with no bubble on ready_out.
- data_in is never sampled when valid_in=0. Lanes are not zeroed on idle cycles.

Test Plan:
- NUM_LANES=4, group_ready=1, words A0,A1,A2,A3 on consecutive cycles -> cycle after A3: group_valid=1 for 1 cycle, lanes_out lanes0..3=A0..A3, lane_valid=4'b1111, group_count=1, lane_ptr=0.
- Words B0,B1 then flush_in=1 alone -> next cycle lanes_out=B0,B1,0,0, lane_valid=4'b0011, group_valid=1. flush_in on an empty accumulator -> group_valid stays 0.
- Word C3 into slot 3 with flush_in=1 in the same cycle -> exactly one group with lane_valid=4'b1111. No second, empty group follows.
- group_ready=0, 8 words D0..D7 streamed:
  - first group D0..D3 is held stable on the output;
  - after D7 is accepted, ready_out=0;
  - raise group_ready -> D0..D3 handshakes, D4..D7 appears the next cycle, ready_out returns to 1, group_count=2.
- Reset pulsed for 1 cycle after E0..E2 are accepted -> all outputs 0. Then F0..F3 -> group lanes0..3=F0..F3 with no E data, lane_valid=4'b1111.
- CNT_W=2, 5 full groups sent -> group_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/byte_striping_n_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_striping_n_if
// Purpose  : Bus bundle for the N-lane byte striper. Carries the word-input
//            valid/ready/flush handshake and the parallel lane-group output
//            valid/ready handshake.
// Ports    : master - environment side (drives words, flush, group_ready)
//            slave  - striper side (drives ready_out and the lane group)
// Revision : 1.0 - initial release
// ============================================================================
interface byte_striping_n_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_LANES = 4
);
  logic [DATA_W-1:0]           data_in;
  logic                        valid_in;
  logic                        ready_out;
  logic                        flush_in;
  logic [NUM_LANES*DATA_W-1:0] lanes_out;
  logic [NUM_LANES-1:0]        lane_valid;
  logic                        group_valid;
  logic                        group_ready;

  modport master (
    output data_in, valid_in, flush_in, group_ready,
    input  ready_out, lanes_out, lane_valid, group_valid
  );

  modport slave (
    input  data_in, valid_in, flush_in, group_ready,
    output ready_out, lanes_out, lane_valid, group_valid
  );
endinterface
`default_nettype wire

// File: rtl/byte_striping_n.sv
`default_nettype none
// ============================================================================
// Module   : byte_striping_n
// Purpose  : Distributes one DATA_W word per cycle round-robin over NUM_LANES
//            accumulator slots and hands each completed (or flushed partial)
//            group to a held valid/ready output stage. Unfilled lanes of a
//            flushed group carry PAD_WORD and are flagged in lane_valid.
// Ports    : clk         - single clock, all logic on posedge
//            reset       - synchronous active-high reset
//            bus         - word input handshake + lane group output handshake
//            lane_ptr    - next accumulator slot to fill
//            group_count - groups handed to the output, wraps mod 2^CNT_W
// Revision : 1.0 - initial release
// ============================================================================
module byte_striping_n #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_LANES = 4,   // legal range 2..16
  parameter logic [DATA_W-1:0] PAD_WORD  = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  byte_striping_n_if.slave             bus,
  output logic [$clog2(NUM_LANES)-1:0] lane_ptr,
  output logic [CNT_W-1:0]             group_count
);

  localparam int unsigned PTR_W = $clog2(NUM_LANES);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_LANES - 1);

  // Accumulator and its per-slot filled flags
  logic [NUM_LANES-1:0][DATA_W-1:0] acc_q, acc_d, acc_cur;
  logic [NUM_LANES-1:0]             fill_q, fill_d, fill_cur;
  logic [PTR_W-1:0]                 ptr_q, ptr_d;
  // A completed group is waiting for the output stage to free up
  logic                             pending_q, pending_d;

  // Held output stage
  logic [NUM_LANES-1:0][DATA_W-1:0] lanes_q, lanes_d;
  logic [NUM_LANES-1:0]             lane_valid_q, lane_valid_d;
  logic                             group_valid_q, group_valid_d;
  logic [CNT_W-1:0]                 count_q, count_d;

  logic ready;
  logic accept;
  logic last_hit;
  logic flush_hit;
  logic complete;
  logic out_free;
  logic transfer;

  always_comb begin
    ready    = !reset && !pending_q;
    accept   = bus.valid_in && ready;

    // Accumulator view including a word accepted this cycle, so that a flush
    // in the same cycle closes the group with that word in it.
    acc_cur  = acc_q;
    fill_cur = fill_q;
    if (accept) begin
      acc_cur[ptr_q]  = bus.data_in;
      fill_cur[ptr_q] = 1'b1;
    end

    last_hit  = accept && (ptr_q == LAST_SLOT);
    // Flush is ignored while pending (ready is low, accumulator frozen) and
    // is a no-op on an empty accumulator.
    flush_hit = bus.flush_in && !pending_q && (|fill_cur);
    // last_hit and flush_hit together still describe a single group.
    complete  = last_hit || flush_hit;
    out_free  = !group_valid_q || bus.group_ready;
    transfer  = (complete || pending_q) && out_free;

    acc_d     = acc_cur;
    fill_d    = transfer ? '0 : fill_cur;
    pending_d = transfer ? 1'b0 : (pending_q || complete);

    ptr_d = ptr_q;
    if (transfer || last_hit) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = ptr_q + PTR_W'(1);
    end

    lanes_d       = lanes_q;
    lane_valid_d  = lane_valid_q;
    group_valid_d = group_valid_q;
    count_d       = count_q;
    if (transfer) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        lanes_d[k] = fill_cur[k] ? acc_cur[k] : PAD_WORD;
      end
      lane_valid_d  = fill_cur;
      group_valid_d = 1'b1;
      count_d       = count_q + CNT_W'(1);
    end else if (group_valid_q && bus.group_ready) begin
      // Lane data is left as-is; only the qualifiers drop.
      lane_valid_d  = '0;
      group_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      fill_q        <= '0;
      ptr_q         <= '0;
      pending_q     <= 1'b0;
      lanes_q       <= '0;
      lane_valid_q  <= '0;
      group_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      acc_q         <= acc_d;
      fill_q        <= fill_d;
      ptr_q         <= ptr_d;
      pending_q     <= pending_d;
      lanes_q       <= lanes_d;
      lane_valid_q  <= lane_valid_d;
      group_valid_q <= group_valid_d;
      count_q       <= count_d;
    end
  end

  assign bus.ready_out   = ready;
  assign bus.lanes_out   = lanes_q;
  assign bus.lane_valid  = lane_valid_q;
  assign bus.group_valid = group_valid_q;
  assign lane_ptr        = ptr_q;
  assign group_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_striping_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_striping_n
// Purpose  : Self-checking bench for byte_striping_n (NUM_LANES=4, DATA_W=32).
//            A table of per-cycle vectors covers full groups, flush, flush with
//            the last word, and back-pressure; hand-written sequences cover
//            mid-operation reset and group_count wrap on a CNT_W=2 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_striping_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  byte_striping_n_if #(.DATA_W(32), .NUM_LANES(4)) bus  ();
  byte_striping_n_if #(.DATA_W(32), .NUM_LANES(4)) bus2 ();

  logic [1:0]  lane_ptr, lane_ptr2;
  logic [15:0] group_count;
  logic [1:0]  group_count2;

  // Second instance sees identical stimulus; only its counter width differs.
  assign bus2.data_in     = bus.data_in;
  assign bus2.valid_in    = bus.valid_in;
  assign bus2.flush_in    = bus.flush_in;
  assign bus2.group_ready = bus.group_ready;

  byte_striping_n #(.DATA_W(32), .NUM_LANES(4), .PAD_WORD(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .lane_ptr(lane_ptr), .group_count(group_count)
  );

  byte_striping_n #(.DATA_W(32), .NUM_LANES(4), .PAD_WORD(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .lane_ptr(lane_ptr2), .group_count(group_count2)
  );

  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic         f;
    logic         gr;
    logic         rdy;
    logic         gv;
    logic [3:0]   lv;
    logic         chk_lanes;
    logic [127:0] lanes;
    logic [15:0]  cnt;
    logic [1:0]   ptr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] wd(input logic [7:0] tag, input int i);
    return {tag, 16'h5A5A, 8'(i)};
  endfunction

  function automatic logic [127:0] grp(input logic [31:0] l0, input logic [31:0] l1,
                                       input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic f, input logic gr,
                              input logic rdy, input logic gv, input logic [3:0] lv,
                              input logic cl, input logic [127:0] lanes,
                              input logic [15:0] cnt, input logic [1:0] ptr);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.gr = gr; r.rdy = rdy; r.gv = gv; r.lv = lv;
    r.chk_lanes = cl; r.lanes = lanes; r.cnt = cnt; r.ptr = ptr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic f, input logic gr);
    @(negedge clk);
    bus.valid_in    = v;
    bus.data_in     = d;
    bus.flush_in    = f;
    bus.group_ready = gr;
  endtask

  // One-cycle reset pulse; ready_out must be low while reset is high.
  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.flush_in    = 1'b0;
    bus.group_ready = 1'b1;
    #1 chk("rst.ready_out_during", 128'(bus.ready_out), 128'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl [33];
  logic [31:0] A [4], B [4], C [4], D [8];
  int exp_cnt2 [5] = '{1, 2, 3, 0, 1};

  initial begin
    for (int i = 0; i < 4; i++) begin
      A[i] = wd(8'hAA, i); B[i] = wd(8'hBB, i); C[i] = wd(8'hCC, i);
    end
    for (int i = 0; i < 8; i++) D[i] = wd(8'hDD, i);

    // Expected fields describe what is visible during the cycle the inputs
    // are applied, i.e. the effect of earlier clock edges.
    tbl[0]  = mk(0, 0,    0, 1, 1, 0, 4'h0, 1, '0, 0, 0);
    tbl[1]  = mk(1, A[0], 0, 1, 1, 0, 4'h0, 0, '0, 0, 0);
    tbl[2]  = mk(1, A[1], 0, 1, 1, 0, 4'h0, 0, '0, 0, 1);
    tbl[3]  = mk(1, A[2], 0, 1, 1, 0, 4'h0, 0, '0, 0, 2);
    tbl[4]  = mk(1, A[3], 0, 1, 1, 0, 4'h0, 0, '0, 0, 3);
    tbl[5]  = mk(0, 0,    0, 1, 1, 1, 4'hF, 1, grp(A[0], A[1], A[2], A[3]), 1, 0);
    tbl[6]  = mk(0, 0,    0, 1, 1, 0, 4'h0, 0, '0, 1, 0);
    tbl[7]  = mk(1, B[0], 0, 1, 1, 0, 4'h0, 0, '0, 1, 0);
    tbl[8]  = mk(1, B[1], 0, 1, 1, 0, 4'h0, 0, '0, 1, 1);
    tbl[9]  = mk(0, 0,    1, 1, 1, 0, 4'h0, 0, '0, 1, 2);
    tbl[10] = mk(0, 0,    0, 1, 1, 1, 4'h3, 1, grp(B[0], B[1], 0, 0), 2, 0);
    tbl[11] = mk(0, 0,    1, 1, 1, 0, 4'h0, 0, '0, 2, 0);
    tbl[12] = mk(0, 0,    0, 1, 1, 0, 4'h0, 0, '0, 2, 0);
    tbl[13] = mk(1, C[0], 0, 1, 1, 0, 4'h0, 0, '0, 2, 0);
    tbl[14] = mk(1, C[1], 0, 1, 1, 0, 4'h0, 0, '0, 2, 1);
    tbl[15] = mk(1, C[2], 0, 1, 1, 0, 4'h0, 0, '0, 2, 2);
    tbl[16] = mk(1, C[3], 1, 1, 1, 0, 4'h0, 0, '0, 2, 3);
    tbl[17] = mk(0, 0,    0, 1, 1, 1, 4'hF, 1, grp(C[0], C[1], C[2], C[3]), 3, 0);
    tbl[18] = mk(0, 0,    0, 1, 1, 0, 4'h0, 0, '0, 3, 0);
    tbl[19] = mk(0, 0,    0, 1, 1, 0, 4'h0, 0, '0, 3, 0);
    tbl[20] = mk(1, D[0], 0, 0, 1, 0, 4'h0, 0, '0, 3, 0);
    tbl[21] = mk(1, D[1], 0, 0, 1, 0, 4'h0, 0, '0, 3, 1);
    tbl[22] = mk(1, D[2], 0, 0, 1, 0, 4'h0, 0, '0, 3, 2);
    tbl[23] = mk(1, D[3], 0, 0, 1, 0, 4'h0, 0, '0, 3, 3);
    tbl[24] = mk(1, D[4], 0, 0, 1, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 0);
    tbl[25] = mk(1, D[5], 0, 0, 1, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 1);
    tbl[26] = mk(1, D[6], 0, 0, 1, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 2);
    tbl[27] = mk(1, D[7], 0, 0, 1, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 3);
    tbl[28] = mk(0, 0,    0, 0, 0, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 0);
    tbl[29] = mk(0, 0,    0, 0, 0, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 0);
    tbl[30] = mk(0, 0,    0, 1, 0, 1, 4'hF, 1, grp(D[0], D[1], D[2], D[3]), 4, 0);
    tbl[31] = mk(0, 0,    0, 1, 1, 1, 4'hF, 1, grp(D[4], D[5], D[6], D[7]), 5, 0);
    tbl[32] = mk(0, 0,    0, 1, 1, 0, 4'h0, 0, '0, 5, 0);

    reset           = 1'b1;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.flush_in    = 1'b0;
    bus.group_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].gr);
      #1;
      chk($sformatf("v%0d.ready_out", i),   128'(bus.ready_out),   128'(tbl[i].rdy));
      chk($sformatf("v%0d.group_valid", i), 128'(bus.group_valid), 128'(tbl[i].gv));
      chk($sformatf("v%0d.lane_valid", i),  128'(bus.lane_valid),  128'(tbl[i].lv));
      chk($sformatf("v%0d.group_count", i), 128'(group_count),     128'(tbl[i].cnt));
      chk($sformatf("v%0d.lane_ptr", i),    128'(lane_ptr),        128'(tbl[i].ptr));
      if (tbl[i].chk_lanes)
        chk($sformatf("v%0d.lanes_out", i), bus.lanes_out, tbl[i].lanes);
    end

    // ---------------- reset mid-operation ----------------
    // Hold a full group on the output and leave three words in the accumulator.
    for (int i = 0; i < 4; i++) drive(1, wd(8'h96, i), 0, 0);
    for (int i = 0; i < 3; i++) drive(1, wd(8'hEE, i), 0, 0);
    #1 chk("rst.pre_group_valid", 128'(bus.group_valid), 128'(1));
    do_reset();
    #1;
    chk("rst.group_valid", 128'(bus.group_valid), 128'(0));
    chk("rst.lane_valid",  128'(bus.lane_valid),  128'(0));
    chk("rst.lanes_out",   bus.lanes_out,         128'(0));
    chk("rst.group_count", 128'(group_count),     128'(0));
    chk("rst.lane_ptr",    128'(lane_ptr),        128'(0));
    chk("rst.ready_out",   128'(bus.ready_out),   128'(1));
    for (int i = 0; i < 4; i++) drive(1, wd(8'hFF, i), 0, 1);
    drive(0, 0, 0, 1);
    #1;
    chk("rstF.group_valid", 128'(bus.group_valid), 128'(1));
    chk("rstF.lane_valid",  128'(bus.lane_valid),  128'(4'hF));
    chk("rstF.lanes_out",   bus.lanes_out,
        grp(wd(8'hFF, 0), wd(8'hFF, 1), wd(8'hFF, 2), wd(8'hFF, 3)));
    chk("rstF.group_count", 128'(group_count),     128'(1));

    // ---------------- group_count wrap (CNT_W=2) + back-to-back ----------------
    do_reset();
    #1 chk("wrap.cnt_reset", 128'(group_count2), 128'(0));
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1, wd(8'h11, g * 4 + i), 0, 1);
        #1;
        chk($sformatf("wrap.g%0d.w%0d.ready_out", g, i), 128'(bus.ready_out), 128'(1));
        if (i == 0 && g > 0) begin
          chk($sformatf("wrap.g%0d.group_valid", g), 128'(bus.group_valid), 128'(1));
          chk($sformatf("wrap.g%0d.count2", g), 128'(group_count2), 128'(exp_cnt2[g-1]));
        end
      end
    end
    drive(0, 0, 0, 1);
    #1;
    chk("wrap.final.count2",      128'(group_count2),    128'(exp_cnt2[4]));
    chk("wrap.final.count16",     128'(group_count),     128'(5));
    chk("wrap.final.lanes_out",   bus.lanes_out,
        grp(wd(8'h11, 16), wd(8'h11, 17), wd(8'h11, 18), wd(8'h11, 19)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
